// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared FP format defaults, rounding modes and status bit indices
// Shared by fp_to_int and the FP add/sub unit so rounding behaviour stays identical.
package fp_pkg;

  localparam int FP_EXP_W  = 5;
  localparam int FP_FRAC_W = 10;
  localparam int FP_BIAS   = 15;

  typedef enum logic [2:0] {
    RND_RNE = 3'd0,
    RND_RTZ = 3'd1,
    RND_RUP = 3'd2,
    RND_RDN = 3'd3,
    RND_RNA = 3'd4
  } rnd_mode_e;

  localparam int ST_INVALID = 0;
  localparam int ST_INEXACT = 1;
  localparam int ST_ZERO    = 2;
  localparam int ST_DENORM  = 3;

endpackage

// File: rtl/fp_round.sv
// rtl/fp_round.sv - magnitude rounding from guard/sticky bits, sign-aware directed modes
// Unlisted mode encodings fall through to round-to-nearest-even.
module fp_round
  import fp_pkg::*;
#(
  parameter int P_W = 16
) (
  input  logic [P_W-1:0] mag_i,
  input  logic           guard_i,
  input  logic           sticky_i,
  input  logic           sign_i,
  input  logic [2:0]     rnd_i,
  output logic [P_W:0]   mag_o,
  output logic           inexact_o
);

  logic inc;

  always_comb begin
    inc = 1'b0;
    case (rnd_i)
      RND_RTZ: inc = 1'b0;
      RND_RUP: inc = (guard_i | sticky_i) & ~sign_i;
      RND_RDN: inc = (guard_i | sticky_i) & sign_i;
      RND_RNA: inc = guard_i;
      default: inc = guard_i & (sticky_i | mag_i[0]);
    endcase
  end

  assign mag_o     = {1'b0, mag_i} + {{P_W{1'b0}}, inc};
  assign inexact_o = guard_i | sticky_i;

endmodule

// File: rtl/fp_to_int.sv
// rtl/fp_to_int.sv - 2-stage FP to signed integer converter with valid/ready handshake
// S1 decodes and aligns to integer + guard/sticky; S2 rounds, saturates and flags.
module fp_to_int
  import fp_pkg::*;
#(
  parameter int P_EXP  = FP_EXP_W,
  parameter int P_FRAC = FP_FRAC_W,
  parameter int P_BIAS = FP_BIAS,
  parameter int P_WORD = 1 + P_EXP + P_FRAC,
  parameter int P_INT  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [P_WORD-1:0] a,
  input  logic [2:0]        rnd,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [P_INT-1:0]  z,
  output logic [7:0]        status
);

  localparam int SHW = P_FRAC + P_BIAS;
  localparam logic [P_INT:0]   LIM_POS = {2'b00, {(P_INT-1){1'b1}}};
  localparam logic [P_INT:0]   LIM_NEG = {2'b01, {(P_INT-1){1'b0}}};
  localparam logic [P_INT-1:0] Z_MAX   = {1'b0, {(P_INT-1){1'b1}}};
  localparam logic [P_INT-1:0] Z_MIN   = {1'b1, {(P_INT-1){1'b0}}};

  logic                sign_w;
  logic [P_EXP-1:0]    exp_w;
  logic [P_FRAC-1:0]   frac_w;
  logic [P_FRAC:0]     sig_w;
  logic [P_FRAC+SHW:0] ext_w;
  int                  e_w;

  logic [P_INT-1:0] mag_d;
  logic             guard_d, sticky_d, big_d, nan_d, denorm_d;

  logic             s1_vld_q, s1_sign_q, s1_guard_q, s1_sticky_q;
  logic             s1_big_q, s1_nan_q, s1_denorm_q;
  logic [P_INT-1:0] s1_mag_q;
  logic [2:0]       s1_rnd_q;

  logic             out_vld_q;
  logic [P_INT-1:0] z_q, z_d;
  logic [7:0]       status_q, status_d;

  logic             s2_adv, in_fire, inv_w, inexact_w;
  logic [P_INT:0]   rmag_w;

  assign {sign_w, exp_w, frac_w} = a;

  assign s2_adv  = !out_vld_q || out_rdy;
  assign in_rdy  = !rst && (!s1_vld_q || s2_adv);
  assign in_fire = in_vld && in_rdy;

  // Right shifts park discarded bits below the integer field so guard/sticky fall out directly.
  always_comb begin
    sig_w    = {(exp_w != '0), frac_w};
    e_w      = (exp_w == '0) ? 1 - P_BIAS : int'(exp_w) - P_BIAS;
    ext_w    = '0;
    mag_d    = '0;
    guard_d  = 1'b0;
    sticky_d = 1'b0;
    nan_d    = (&exp_w) && (frac_w != '0);
    big_d    = (&exp_w) || (e_w >= P_INT);
    denorm_d = (exp_w == '0) && (frac_w != '0);
    if (e_w >= P_FRAC) begin
      mag_d = P_INT'(sig_w) << (e_w - P_FRAC);
    end else begin
      ext_w    = {sig_w, {SHW{1'b0}}} >> (P_FRAC - e_w);
      mag_d    = P_INT'(ext_w[P_FRAC+SHW -: P_FRAC+1]);
      guard_d  = ext_w[SHW-1];
      sticky_d = |ext_w[SHW-2:0];
    end
  end

  fp_round #(.P_W(P_INT)) u_round (
    .mag_i     (s1_mag_q),
    .guard_i   (s1_guard_q),
    .sticky_i  (s1_sticky_q),
    .sign_i    (s1_sign_q),
    .rnd_i     (s1_rnd_q),
    .mag_o     (rmag_w),
    .inexact_o (inexact_w)
  );

  // Negative side may reach exactly 2^(P_INT-1) without saturating.
  always_comb begin
    inv_w = 1'b1;
    z_d   = Z_MAX;
    if (s1_nan_q) begin
      z_d = Z_MAX;
    end else if (s1_big_q || (s1_sign_q ? (rmag_w > LIM_NEG) : (rmag_w > LIM_POS))) begin
      z_d = s1_sign_q ? Z_MIN : Z_MAX;
    end else begin
      inv_w = 1'b0;
      z_d   = s1_sign_q ? (~rmag_w[P_INT-1:0] + P_INT'(1)) : rmag_w[P_INT-1:0];
    end
    status_d             = '0;
    status_d[ST_INVALID] = inv_w;
    status_d[ST_INEXACT] = inexact_w && !inv_w;
    status_d[ST_ZERO]    = (z_d == '0);
    status_d[ST_DENORM]  = s1_denorm_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      out_vld_q <= 1'b0;
      z_q       <= '0;
      status_q  <= '0;
    end else begin
      if (in_fire) begin
        s1_vld_q <= 1'b1;
      end else if (s2_adv) begin
        s1_vld_q <= 1'b0;
      end
      if (s2_adv) begin
        out_vld_q <= s1_vld_q;
        if (s1_vld_q) begin
          z_q      <= z_d;
          status_q <= status_d;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_sign_q   <= sign_w;
      s1_mag_q    <= mag_d;
      s1_guard_q  <= guard_d;
      s1_sticky_q <= sticky_d;
      s1_big_q    <= big_d;
      s1_nan_q    <= nan_d;
      s1_denorm_q <= denorm_d;
      s1_rnd_q    <= rnd;
    end
  end

  assign out_vld = out_vld_q;
  assign z       = z_q;
  assign status  = status_q;

endmodule
